// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the five-stage MIPS core.
// Holds the hazard idle value, ExcCode constants and the common field widths.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PC_W       = 32;
  localparam int TUSE_IDLE  = 4;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t EXC_INT     = 5'd0;
  localparam exc_code_t EXC_ADEL    = 5'd4;
  localparam exc_code_t EXC_ADES    = 5'd5;
  localparam exc_code_t EXC_SYSCALL = 5'd8;
  localparam exc_code_t EXC_RI      = 5'd10;
  localparam exc_code_t EXC_OV      = 5'd12;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Wrap-around performance counter with asynchronous reset and increment enable.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // next count: wraps modulo 2^CNT_W, never saturates
  always_comb begin
    cnt_s = cnt_r;
    if (inc) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // counter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying payload plus hazard/exception fields,
// with prioritised flush/stall control and stall/bubble performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W        = 128,
  parameter int TNEW_W           = 4,
  parameter int TNEW_DEC         = 1,
  parameter int KEEP_PC_ON_FLUSH = 1,
  parameter int CNT_W            = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  in_bd,
  input  logic [REG_ADDR_W-1:0] in_dst_addr,
  input  logic [TNEW_W-1:0]     in_tnew,
  input  logic [TNEW_W-1:0]     in_rs_tuse,
  input  logic [TNEW_W-1:0]     in_rt_tuse,
  input  logic                  in_exc,
  input  logic [4:0]            in_exc_code,
  output logic                  out_valid,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic [PC_W-1:0]       out_pc,
  output logic                  out_bd,
  output logic [REG_ADDR_W-1:0] out_dst_addr,
  output logic [TNEW_W-1:0]     out_tnew,
  output logic [TNEW_W-1:0]     out_rs_tuse,
  output logic [TNEW_W-1:0]     out_rt_tuse,
  output logic                  out_exc,
  output logic [4:0]            out_exc_code,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam logic [TNEW_W-1:0] TUSE_IDLE_V = TNEW_W'(TUSE_IDLE);
  localparam logic [TNEW_W-1:0] TNEW_DEC_V  = TNEW_W'(TNEW_DEC);
  localparam logic              KEEP_PC     = (KEEP_PC_ON_FLUSH != 0);

  logic                  valid_r,    valid_s;
  logic [PAYLOAD_W-1:0]  payload_r,  payload_s;
  logic [PC_W-1:0]       pc_r,       pc_s;
  logic                  bd_r,       bd_s;
  logic [REG_ADDR_W-1:0] dst_r,      dst_s;
  logic [TNEW_W-1:0]     tnew_r,     tnew_s;
  logic [TNEW_W-1:0]     rs_tuse_r,  rs_tuse_s;
  logic [TNEW_W-1:0]     rt_tuse_r,  rt_tuse_s;
  logic                  exc_r,      exc_s;
  exc_code_t             exc_code_r, exc_code_s;

  logic                  bubble_s;
  logic                  stall_inc_s;
  logic                  bubble_inc_s;
  logic [PC_W-1:0]       bubble_pc_s;
  logic                  bubble_bd_s;

  // a bubble is loaded on flush, or on a normal load with no real instruction upstream
  always_comb begin
    bubble_s     = 1'b0;
    stall_inc_s  = 1'b0;
    bubble_inc_s = 1'b0;
    if (flush) begin
      bubble_s     = 1'b1;
      bubble_inc_s = 1'b1;
    end else if (stall) begin
      stall_inc_s  = 1'b1;
    end else begin
      bubble_s     = ~in_valid;
    end
  end

  // bubbles keep the incoming PC/BD so a later exception still reports the right EPC
  always_comb begin
    if (KEEP_PC) begin
      bubble_pc_s = in_pc;
      bubble_bd_s = in_bd;
    end else begin
      bubble_pc_s = {PC_W{1'b0}};
      bubble_bd_s = 1'b0;
    end
  end

  // next-state selection: bubble, hold or load
  always_comb begin
    valid_s    = valid_r;
    payload_s  = payload_r;
    pc_s       = pc_r;
    bd_s       = bd_r;
    dst_s      = dst_r;
    tnew_s     = tnew_r;
    rs_tuse_s  = rs_tuse_r;
    rt_tuse_s  = rt_tuse_r;
    exc_s      = exc_r;
    exc_code_s = exc_code_r;
    if (bubble_s) begin
      valid_s    = 1'b0;
      payload_s  = {PAYLOAD_W{1'b0}};
      pc_s       = bubble_pc_s;
      bd_s       = bubble_bd_s;
      dst_s      = {REG_ADDR_W{1'b0}};
      tnew_s     = {TNEW_W{1'b0}};
      rs_tuse_s  = TUSE_IDLE_V;
      rt_tuse_s  = TUSE_IDLE_V;
      exc_s      = 1'b0;
      exc_code_s = EXC_INT;
    end else if (stall) begin
      valid_s    = valid_r;
    end else begin
      valid_s    = 1'b1;
      payload_s  = in_payload;
      pc_s       = in_pc;
      bd_s       = in_bd;
      dst_s      = in_dst_addr;
      tnew_s     = in_tnew;
      rs_tuse_s  = in_rs_tuse;
      rt_tuse_s  = in_rt_tuse;
      exc_s      = in_exc;
      exc_code_s = in_exc_code;
    end
  end

  // stage state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r    <= 1'b0;
      payload_r  <= {PAYLOAD_W{1'b0}};
      pc_r       <= {PC_W{1'b0}};
      bd_r       <= 1'b0;
      dst_r      <= {REG_ADDR_W{1'b0}};
      tnew_r     <= {TNEW_W{1'b0}};
      rs_tuse_r  <= TUSE_IDLE_V;
      rt_tuse_r  <= TUSE_IDLE_V;
      exc_r      <= 1'b0;
      exc_code_r <= EXC_INT;
    end else begin
      valid_r    <= valid_s;
      payload_r  <= payload_s;
      pc_r       <= pc_s;
      bd_r       <= bd_s;
      dst_r      <= dst_s;
      tnew_r     <= tnew_s;
      rs_tuse_r  <= rs_tuse_s;
      rt_tuse_r  <= rt_tuse_s;
      exc_r      <= exc_s;
      exc_code_r <= exc_code_s;
    end
  end

  // Tnew saturates at 0; a faulting instruction is hidden from hazard unit and GRF
  always_comb begin
    if (tnew_r >= TNEW_DEC_V) begin
      out_tnew = tnew_r - TNEW_DEC_V;
    end else begin
      out_tnew = {TNEW_W{1'b0}};
    end
    if (exc_r) begin
      out_dst_addr = {REG_ADDR_W{1'b0}};
    end else begin
      out_dst_addr = dst_r;
    end
  end

  assign out_valid    = valid_r;
  assign out_payload  = payload_r;
  assign out_pc       = pc_r;
  assign out_bd       = bd_r;
  assign out_rs_tuse  = rs_tuse_r;
  assign out_rt_tuse  = rt_tuse_r;
  assign out_exc      = exc_r;
  assign out_exc_code = exc_code_r;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc_s),
    .cnt   (bubble_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. One instance sits between each pair of stages: IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an opaque control/data payload plus the hazard-tracking fields:

- destination register address
- Tnew countdown
- rs/rt Tuse
- exception flag and code
- PC and branch-delay flag

Over the previous fixed-width stage registers it adds:

- separate stall (hold) and flush (bubble) controls with defined priority
- a valid bit
- exception-driven write suppression
- EPC-preserving bubbles
- per-stage stall and bubble performance counters

## Interface

Parameters:

- PAYLOAD_W, 128, width of the opaque payload (decoded control plus operand values).
- TNEW_W, 4, width of the Tnew and Tuse fields.
- TNEW_DEC, 1, amount the output Tnew is reduced by relative to the stored value (0 in IF/ID, 1 elsewhere).
- KEEP_PC_ON_FLUSH, 1, when 1 a bubble keeps the incoming PC and BD so the exception PC stays correct.
- CNT_W, 32, width of the performance counters.

Ports (clock and reset first):

- clk  in  1  stage clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hold the current contents.
- flush  in  1  load a bubble instead of the input.
- in_valid  in  1  upstream holds a real instruction.
- in_payload  in  PAYLOAD_W  opaque payload.
- in_pc  in  32  instruction PC.
- in_bd  in  1  instruction is in a branch delay slot.
- in_dst_addr  in  5  GRF destination (0 = none).
- in_tnew  in  TNEW_W  cycles until the result is available.
- in_rs_tuse / in_rt_tuse  in  TNEW_W  cycles until the operand is needed.
- in_exc  in  1  exception already raised upstream.
- in_exc_code  in  5  ExcCode of that exception.
- out_valid, out_payload, out_pc, out_bd, out_exc, out_exc_code  out  match the widths above  stored values.
- out_dst_addr  out  5  stored destination, forced to 0 while out_exc=1.
- out_tnew  out  TNEW_W  stored Tnew decremented by TNEW_DEC, saturating at 0.
- out_rs_tuse / out_rt_tuse  out  TNEW_W  stored values.
- stall_cnt  out  CNT_W  cycles in which stall=1 and flush=0.
- bubble_cnt  out  CNT_W  cycles in which flush=1.

## Operation

Reset is applied asynchronously and clears every field:

- out_valid=0, out_payload=0, out_pc=0, out_bd=0, out_dst_addr=0.
- Stored Tnew=0, so out_tnew=0.
- out_rs_tuse = out_rt_tuse = TUSE_IDLE (4).
- out_exc=0, out_exc_code=0.
- Both counters = 0.

Each rising edge with reset low applies the first matching rule, in this priority:

1. **flush=1 (bubble).** Sets valid=0, payload=0, dst_addr=0, Tnew=0, rs/rt Tuse=TUSE_IDLE, exc=0, exc_code=0.
   - PC and BD load in_pc/in_bd if KEEP_PC_ON_FLUSH=1.
   - Otherwise PC and BD are cleared to 0.
   - bubble_cnt increments.
2. **stall=1 (hold).** All fields hold; stall_cnt increments.
3. **Otherwise (load).** All fields load from their inputs.
   - If in_valid=0, the fields are loaded as a bubble, keeping the PC/BD rule above; no counter increments.

Output rules:

- **Tnew.** Combinational: out_tnew = (stored ≥ TNEW_DEC) ? stored − TNEW_DEC : 0.
- **Write suppression.** While out_exc=1:
  - out_dst_addr reads 0, so the hazard unit and GRF see no writer.
  - out_payload passes through unchanged; downstream uses out_exc to gate memory writes.
- **Counters.** Both counters wrap modulo 2^CNT_W and never saturate.

## Timing

- Latency is one cycle from input to output on a load.
- All outputs are registered, except out_tnew and out_dst_addr, which add one level of combinational gating after the registers.
- flush and stall both high in the same cycle: the flush wins, and only bubble_cnt increments.
- Stall held for N cycles: outputs stay constant for N cycles and stall_cnt rises by exactly N.
- Reset asserted mid-stall or mid-flush: outputs take their reset values immediately, without waiting for an edge.
- Reset deasserted: the first edge with reset low acts normally.
- Tnew of 0 stays 0 at the output (no underflow).
- TNEW_DEC=0: out_tnew equals the stored value.

## Structure

- The shared package pipe_pkg holds:
  - TUSE_IDLE = 4
  - the ExcCode constants (INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12)
  - the exc_code_t typedef
  - the widths REG_ADDR_W=5 and PC_W=32
- One sub-module, pipe_perf_cnt: a CNT_W wrap-around counter with asynchronous reset and an increment enable. It is instantiated twice, for stall_cnt and bubble_cnt.

## Test plan

- **Reset.** Assert reset between edges with the register loaded → out_valid=0, out_dst_addr=0, out_rs_tuse=4, out_rt_tuse=4, stall_cnt=0, all immediately.
- **Load then stall.** in_pc=0x3004, in_dst_addr=8, in_tnew=3, TNEW_DEC=1 → next edge out_tnew=2, out_dst_addr=8. Then stall for 3 cycles with inputs changing → outputs unchanged and stall_cnt=3.
- **Flush while stalled.** Hold stall=1 and flush=1 with in_pc=0x3010, in_bd=1, KEEP_PC_ON_FLUSH=1 → out_valid=0, out_pc=0x3010, out_bd=1, out_tnew=0, bubble_cnt=1, stall_cnt unchanged.
- **Exception.** Load in_exc=1, in_exc_code=12, in_dst_addr=9 → out_exc=1, out_exc_code=12, out_dst_addr=0.
- **Tnew saturation.** in_tnew=0 with TNEW_DEC=1 → out_tnew=0. in_tnew=1 → out_tnew=0. in_tnew=15 → out_tnew=14.
- **Counter wrap.** With CNT_W=4, apply 17 stall cycles → stall_cnt=1.
